// File: rtl/systolic_array_pkg.sv
// Shared types for the row buffer and the kernel cell array.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package systolic_array_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Frame-level state: IDLE waits for a start-of-frame pixel, ACTIVE tracks raster position.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/systolic_array_row_buffer_if.sv
// Pixel-in / 3-row-column-out bundle between the pixel source, row buffer and kernel control.
// Latency: n/a (wires only).
// Backpressure: in_val/in_rdy on the input side; output side has no ready.
interface systolic_array_row_buffer_if #(
  parameter int DATA_W = 8
);

  logic              in_val;
  logic              in_rdy;
  logic              in_sof;
  logic [DATA_W-1:0] in_pix;
  logic [DATA_W-1:0] x1;
  logic [DATA_W-1:0] x2;
  logic [DATA_W-1:0] x3;
  logic              x1_val;
  logic              x2_val;
  logic              x3_val;
  logic              new_row;
  logic              frame_done;

  // Row buffer side.
  modport slave (
    input  in_val, in_sof, in_pix,
    output in_rdy, x1, x2, x3, x1_val, x2_val, x3_val, new_row, frame_done
  );

  // Pixel source / kernel control side.
  modport master (
    output in_val, in_sof, in_pix,
    input  in_rdy, x1, x2, x3, x1_val, x2_val, x3_val, new_row, frame_done
  );

endinterface

// File: rtl/systolic_array_row_mem.sv
// One row of pixels: 1W/1R register file, combinational read returning pre-write data.
// Latency: read 0 cycles, write lands on the clock edge.
// Backpressure: none; a write is taken whenever we is high.
module systolic_array_row_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are never cleared: stale pixels are masked downstream by the row-count valids.
  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; the read below sees the old word during the write cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/systolic_array_row_buffer.sv
// 3-row line buffer: presents column pixels of rows r-2, r-1, r with per-row valids.
// Latency: 1 cycle from input accept to registered outputs.
// Backpressure: in_rdy is high every cycle out of reset; no downstream stall.
module systolic_array_row_buffer
  import systolic_array_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  systolic_array_row_buffer_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t            state_q, state_d;
  logic              rdy_q;
  logic [CW-1:0]     col_q, col_d, cur_col;
  logic [RW-1:0]     row_q, row_d, cur_row;
  logic              accept, act, last_pix;
  logic [DATA_W-1:0] mem_a_rd, mem_b_rd;
  logic [DATA_W-1:0] x1_q, x2_q, x3_q;
  logic              x1_val_q, x2_val_q, x3_val_q, new_row_q, frame_done_q;

  // Next state and raster position; a start-of-frame pixel is always (0,0), even mid-frame.
  always_comb begin
    accept   = bus.in_val && rdy_q;
    act      = accept && (bus.in_sof || (state_q == ACTIVE));
    cur_col  = bus.in_sof ? '0 : col_q;
    cur_row  = bus.in_sof ? '0 : row_q;
    last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    if (act) begin
      state_d = last_pix ? IDLE : ACTIVE;
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // State, counters and ready register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rdy_q   <= 1'b1;
    end
  end

  // memA holds row r-1; its old word shifts into memB (row r-2) as the new pixel lands.
  systolic_array_row_mem #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_mem_a (
    .clk   (clk),
    .we    (act),
    .waddr (cur_col),
    .wdata (bus.in_pix),
    .raddr (cur_col),
    .rdata (mem_a_rd)
  );

  systolic_array_row_mem #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_mem_b (
    .clk   (clk),
    .we    (act),
    .waddr (cur_col),
    .wdata (mem_a_rd),
    .raddr (cur_col),
    .rdata (mem_b_rd)
  );

  // Output registers: strobes pulse per accepted pixel, data holds between pixels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      x1_q         <= '0;
      x2_q         <= '0;
      x3_q         <= '0;
      x1_val_q     <= 1'b0;
      x2_val_q     <= 1'b0;
      x3_val_q     <= 1'b0;
      new_row_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x3_val_q     <= act;
      x2_val_q     <= act && (cur_row != '0);
      x1_val_q     <= act && (cur_row > RW'(1));
      new_row_q    <= act && (cur_col == '0);
      frame_done_q <= act && last_pix;
      if (act) begin
        x3_q <= bus.in_pix;
        x2_q <= mem_a_rd;
        x1_q <= mem_b_rd;
      end
    end
  end

  assign bus.in_rdy     = rdy_q;
  assign bus.x1         = x1_q;
  assign bus.x2         = x2_q;
  assign bus.x3         = x3_q;
  assign bus.x1_val     = x1_val_q;
  assign bus.x2_val     = x2_val_q;
  assign bus.x3_val     = x3_val_q;
  assign bus.new_row    = new_row_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_systolic_array_row_buffer.sv
// Scoreboard bench for the row buffer with a frame-array reference model.
// Latency: expects outputs one cycle after each modelled accept.
// Backpressure: drives in_val with random gaps; no output stall exists.
module tb_systolic_array_row_buffer;
  import systolic_array_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    pixel_t x1, x2, x3;
    logic   v1, v2, v3, nr, fd;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b0;
  int     checks = 0;
  int     failures = 0;
  exp_t   q[$];

  // reference model: whole current frame as a 2-D array plus raster position
  pixel_t frame_m [H][W];
  int     mr = 0;
  int     mc = 0;
  bit     mact = 1'b0;

  systolic_array_row_buffer_if #(.DATA_W(8)) bus ();

  systolic_array_row_buffer #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_accept(input pixel_t pix, input bit sof);
    exp_t e;
    if (sof) begin
      mact = 1'b1;
      mr = 0;
      mc = 0;
    end
    if (!mact) return;
    e.v3 = 1'b1;
    e.v2 = (mr >= 1);
    e.v1 = (mr >= 2);
    e.x3 = pix;
    e.x2 = frame_m[(mr >= 1) ? mr - 1 : 0][mc];
    e.x1 = frame_m[(mr >= 2) ? mr - 2 : 0][mc];
    e.nr = (mc == 0);
    e.fd = (mr == H - 1) && (mc == W - 1);
    frame_m[mr][mc] = pix;
    q.push_back(e);
    if (mc == W - 1) begin
      mc = 0;
      if (mr == H - 1) begin
        mr = 0;
        mact = 1'b0;
      end else begin
        mr++;
      end
    end else begin
      mc++;
    end
  endtask

  task automatic drive(input pixel_t pix, input bit sof, input int gap);
    bit acc;
    repeat (gap) begin
      bus.in_val = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_val = 1'b1;
    bus.in_sof = sof;
    bus.in_pix = pix;
    acc = (bus.in_rdy === 1'b1);
    @(posedge clk);
    if (acc) model_accept(pix, sof);
    #1;
    bus.in_val = 1'b0;
    bus.in_sof = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    bus.in_val = 1'b1;
    bus.in_sof = 1'b0;
    bus.in_pix = 8'hAA;
    repeat (n) @(posedge clk);
    mact = 1'b0;
    #1;
    check("rst_in_rdy", {31'b0, bus.in_rdy}, 32'd0);
    check("rst_outputs",
          {3'b0, bus.x1, bus.x2, bus.x3, bus.x1_val, bus.x2_val, bus.x3_val, bus.new_row, bus.frame_done},
          32'd0);
    reset = 1'b1;
    bus.in_val = 1'b0;
    @(posedge clk);
    #1;
    check("rel_in_rdy", {31'b0, bus.in_rdy}, 32'd1);
  endtask

  // Sends pixels base+r*16+c for raster positions [first, last), sof on index 0 if requested.
  task automatic send_range(input pixel_t base, input int first, input int last,
                            input bit sof0, input int gmin, input int gmax);
    for (int i = first; i < last; i++) begin
      pixel_t p;
      p = base + pixel_t'((i / W) * 16 + (i % W));
      drive(p, sof0 && (i == first), $urandom_range(gmax, gmin));
    end
  endtask

  // Scoreboard monitor: every cycle with an output strobe or an outstanding expectation is compared.
  always @(negedge clk) begin
    logic any_out;
    exp_t e;
    bit   bad;
    any_out = bus.x1_val | bus.x2_val | bus.x3_val | bus.new_row | bus.frame_done;
    if (any_out === 1'b1 || q.size() > 0) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL spurious_output vals=%b%b%b new_row=%b frame_done=%b required=none",
                 bus.x1_val, bus.x2_val, bus.x3_val, bus.new_row, bus.frame_done);
      end else begin
        e = q.pop_front();
        bad = (bus.x3_val !== e.v3) || (bus.x2_val !== e.v2) || (bus.x1_val !== e.v1) ||
              (bus.new_row !== e.nr) || (bus.frame_done !== e.fd) ||
              (e.v3 && (bus.x3 !== e.x3)) || (e.v2 && (bus.x2 !== e.x2)) ||
              (e.v1 && (bus.x1 !== e.x1));
        if (bad) begin
          failures++;
          $display("FAIL out_compare actual v=%b%b%b nr=%b fd=%b x=%h/%h/%h required v=%b%b%b nr=%b fd=%b x=%h/%h/%h",
                   bus.x1_val, bus.x2_val, bus.x3_val, bus.new_row, bus.frame_done,
                   bus.x1, bus.x2, bus.x3, e.v1, e.v2, e.v3, e.nr, e.fd, e.x1, e.x2, e.x3);
        end
      end
    end
  end

  initial begin
    bus.in_val = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_pix = '0;

    // reset held with in_val high
    do_reset(3);

    // continuous frame, with a direct look at row 2 col 1
    send_range(8'h00, 0, 9, 1'b1, 0, 0);
    drive(8'h21, 1'b0, 0);
    check("r2c1_x1", {24'b0, bus.x1}, 32'h01);
    check("r2c1_x2", {24'b0, bus.x2}, 32'h11);
    check("r2c1_x3", {24'b0, bus.x3}, 32'h21);
    check("r2c1_vals", {29'b0, bus.x1_val, bus.x2_val, bus.x3_val}, 32'h7);
    send_range(8'h00, 10, W * H, 1'b0, 0, 0);
    check("frame_done_last", {31'b0, bus.frame_done}, 32'd1);

    // back in IDLE: pixels without sof are dropped
    for (int i = 0; i < 6; i++) drive(pixel_t'($urandom), 1'b0, $urandom_range(1, 0));

    // same frame with 1..3-cycle gaps
    send_range(8'h00, 0, W * H, 1'b1, 1, 3);

    // sof in the middle of row 2 restarts the frame
    send_range(8'h00, 0, 2 * W + 2, 1'b1, 0, 1);
    drive(8'h80, 1'b1, 0);
    check("midsof_x1_val", {31'b0, bus.x1_val}, 32'd0);
    check("midsof_x2_val", {31'b0, bus.x2_val}, 32'd0);
    check("midsof_new_row", {31'b0, bus.new_row}, 32'd1);
    send_range(8'h80, 1, W * H, 1'b0, 0, 1);

    // reset in the middle of row 2 aborts the frame
    send_range(8'h00, 0, 2 * W + 2, 1'b1, 0, 1);
    do_reset(2);
    send_range(8'h40, 0, W * H, 1'b1, 0, 2);

    // random pixels, random sof, random gaps
    for (int i = 0; i < 400; i++) begin
      drive(pixel_t'($urandom), (i == 0) || ($urandom_range(15, 0) == 0), $urandom_range(2, 0));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
